// File: rtl/aec_feeder.sv
// Front end of the arithmetic expression calculator. Takes ASCII bytes over a
// valid/ready handshake, drops spaces, checks each character and the length,
// and holds one expression up to '='. The held expression is then sent to the
// calculator one character per cycle with no gaps, and no new input is taken
// until the calculator's result-valid arrives or the wait times out.
//
// state   | meaning
// --------+------------------------------------------------------------
// COLLECT | accepting bytes into the buffer
// DROP    | expression rejected; discarding bytes up to the next '='
// SEND    | sending the buffered chars to the calculator
// WAIT    | waiting for the calculator's result-valid, or the timeout
module aec_feeder #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] ascii_out,
    output logic       ready_out,
    input  logic       aec_valid,
    output logic       err,
    output logic       busy
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST_SLOT = CW'(DEPTH - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {COLLECT, DROP, SEND, WAIT} state_t;

    state_t        state, state_n;
    logic [CW-1:0] wr_cnt, wr_cnt_n;
    logic [CW-1:0] rd_idx, rd_idx_n;
    logic [TW-1:0] to_cnt, to_cnt_n;
    logic [7:0]    ascii_n;
    logic          ready_n;
    logic          err_n;
    logic          buf_we;
    logic [7:0]    buf_mem [DEPTH];

    logic accept;
    logic is_space;
    logic is_eq;
    logic is_legal;

    // The reset term keeps in_ready low while reset is held, even though the
    // state register already reads COLLECT during that time.
    assign in_ready = !rst && (state == COLLECT || state == DROP);
    assign accept   = in_valid && in_ready;
    assign is_space = (in_data == 8'h20);
    assign is_eq    = (in_data == 8'h3d);

    // Character classifier: digits, hex letters a-f, and the operators ( ) * + - =
    always_comb begin
        is_legal = 1'b0;
        if (in_data >= 8'h30 && in_data <= 8'h39)
            is_legal = 1'b1;
        else if (in_data >= 8'h61 && in_data <= 8'h66)
            is_legal = 1'b1;
        else if (in_data inside {8'h28, 8'h29, 8'h2a, 8'h2b, 8'h2d, 8'h3d})
            is_legal = 1'b1;
    end

    // Next-state and next-output logic
    always_comb begin
        state_n  = state;
        wr_cnt_n = wr_cnt;
        rd_idx_n = rd_idx;
        to_cnt_n = to_cnt;
        ascii_n  = 8'h00;
        ready_n  = 1'b0;
        err_n    = 1'b0;
        buf_we   = 1'b0;
        case (state)
            COLLECT: begin
                if (accept && !is_space) begin
                    if (!is_legal) begin
                        state_n = DROP;
                    end else if (is_eq) begin
                        if (wr_cnt == '0) begin
                            err_n = 1'b1;
                        end else begin
                            buf_we   = 1'b1;
                            wr_cnt_n = wr_cnt + CW'(1);
                            rd_idx_n = '0;
                            state_n  = SEND;
                        end
                    end else if (wr_cnt == LAST_SLOT) begin
                        // The last slot is kept for the '='.
                        state_n = DROP;
                    end else begin
                        buf_we   = 1'b1;
                        wr_cnt_n = wr_cnt + CW'(1);
                    end
                end
            end
            DROP: begin
                if (accept && is_eq) begin
                    err_n    = 1'b1;
                    wr_cnt_n = '0;
                    state_n  = COLLECT;
                end
            end
            SEND: begin
                ascii_n  = buf_mem[rd_idx[AW-1:0]];
                ready_n  = 1'b1;
                rd_idx_n = rd_idx + CW'(1);
                if (rd_idx == wr_cnt - CW'(1)) begin
                    state_n  = WAIT;
                    to_cnt_n = '0;
                end
            end
            WAIT: begin
                to_cnt_n = to_cnt + TW'(1);
                if (aec_valid) begin
                    wr_cnt_n = '0;
                    state_n  = COLLECT;
                end else if (to_cnt == TO_LAST) begin
                    err_n    = 1'b1;
                    wr_cnt_n = '0;
                    state_n  = COLLECT;
                end
            end
            default: state_n = COLLECT;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECT;
            wr_cnt    <= '0;
            rd_idx    <= '0;
            to_cnt    <= '0;
            ascii_out <= 8'h00;
            ready_out <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            wr_cnt    <= wr_cnt_n;
            rd_idx    <= rd_idx_n;
            to_cnt    <= to_cnt_n;
            ascii_out <= ascii_n;
            ready_out <= ready_n;
            err       <= err_n;
            busy      <= (state == SEND || state == WAIT);
        end
    end

    // Expression buffer; its contents are not reset
    always_ff @(posedge clk) begin
        if (buf_we)
            buf_mem[wr_cnt[AW-1:0]] <= in_data;
    end
endmodule

// File: tb/tb_aec_feeder.sv
// Testbench for aec_feeder: a table of fixed expressions, exact-timing
// sequences for the burst/timeout/reset cases, and random expressions checked
// against a string-level model of what the calculator should receive.
module tb_aec_feeder;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] ascii_out;
    logic       ready_out;
    logic       aec_valid;
    logic       err;
    logic       busy;

    always #5 clk = ~clk;

    aec_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ascii_out(ascii_out), .ready_out(ready_out),
        .aec_valid(aec_valid), .err(err), .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Output monitor: sampled on the falling edge, away from the active edge
    logic [7:0] got_q[$];
    int  mon_err = 0, mon_runs = 0, mon_busy_bad = 0, mon_idle_bad = 0;
    bit  prev_rdy = 1'b0;
    always @(negedge clk) begin
        if (ready_out === 1'b1) begin
            got_q.push_back(ascii_out);
            if (!prev_rdy) mon_runs++;
            if (busy !== 1'b1) mon_busy_bad++;
        end else if (ascii_out !== 8'h00) begin
            mon_idle_bad++;
        end
        if (err === 1'b1) mon_err++;
        prev_rdy = (ready_out === 1'b1);
    end

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (in_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_timeout: in_ready=%b, expected 1 within 300 cycles", in_ready);
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // Feeds one expression, answers with aec_valid if asked, and returns what
    // the monitor saw while it ran.
    task automatic run_expr(input string s, input bit respond, input int gap_max,
                            output string act, output int errs, output int runs,
                            output int bad_busy, output int bad_idle);
        int g0, e0, r0, b0, i0, t, dly;
        bit seen, fired;
        g0 = got_q.size(); e0 = mon_err; r0 = mon_runs;
        b0 = mon_busy_bad; i0 = mon_idle_bad;
        for (int i = 0; i < s.len(); i++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge clk); #1;
                end
            end
            push_byte(s[i]);
        end
        t = 0; seen = 1'b0; fired = 1'b0;
        dly = $urandom_range(0, 8);
        while (in_ready !== 1'b1 && t < 300) begin
            if (ready_out === 1'b1) begin
                seen = 1'b1;
            end else if (seen && respond && !fired) begin
                repeat (dly) begin
                    @(posedge clk); #1;
                end
                aec_valid = 1'b1;
                fired = 1'b1;
            end
            @(posedge clk); #1;
            aec_valid = 1'b0;
            t++;
        end
        if (in_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: in_ready=%b, expected 1 within 300 cycles", in_ready);
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        act = "";
        for (int i = g0; i < got_q.size(); i++) act = $sformatf("%s%c", act, got_q[i]);
        errs = mon_err - e0;
        runs = mon_runs - r0;
        bad_busy = mon_busy_bad - b0;
        bad_idle = mon_idle_bad - i0;
    endtask

    task automatic check_expr(input string name, input string s, input bit respond,
                              input string exp, input int exp_err, input int gap_max);
        string act;
        int errs, runs, bb, bi;
        run_expr(s, respond, gap_max, act, errs, runs, bb, bi);
        check_str({name, ".emit"}, act, exp);
        check_int({name, ".err"}, errs, exp_err);
        check_int({name, ".runs"}, runs, (exp.len() > 0) ? 1 : 0);
        check_int({name, ".busy_low_in_burst"}, bb, 0);
        check_int({name, ".idle_nonzero"}, bi, 0);
    endtask

    // String-level reference: what reaches the calculator and how many err pulses
    function automatic void model(input string s, input bit respond,
                                  output string exp, output int exp_err);
        string legal_set;
        string kept;
        bit bad, ok;
        logic [7:0] c;
        legal_set = "0123456789abcdef()*+-";
        kept = "";
        bad = 1'b0;
        exp = "";
        exp_err = 0;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c == "=") break;
            if (c != " ") begin
                ok = 1'b0;
                for (int k = 0; k < legal_set.len(); k++)
                    if (legal_set[k] == c) ok = 1'b1;
                if (ok) kept = $sformatf("%s%c", kept, c);
                else bad = 1'b1;
            end
        end
        if (bad || kept.len() > DEPTH - 1 || kept.len() == 0) begin
            exp_err = 1;
        end else begin
            exp = {kept, "="};
            exp_err = respond ? 0 : 1;
        end
    endfunction

    typedef struct {
        string stim;
        bit    respond;
        string exp;
        int    exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string s, input bit r, input string e, input int ee);
        vec_t v;
        v.stim = s; v.respond = r; v.exp = e; v.exp_err = ee;
        return v;
    endfunction

    initial begin
        string exp_s, s, legal_pool, bad_pool, act;
        int exp_e, e0, len, r, idx;
        bit resp;
        logic [7:0] c;

        vecs.push_back(mk("3+4=",               1, "3+4=",             0));
        vecs.push_back(mk("( 1 + 2 ) * 3 =",    1, "(1+2)*3=",         0));
        vecs.push_back(mk("1+g2=",              1, "",                 1));
        vecs.push_back(mk("5-2=",               1, "5-2=",             0));
        vecs.push_back(mk("1234567890abcde6=",  1, "",                 1));
        vecs.push_back(mk("1234567890abcde=",   1, "1234567890abcde=", 0));
        vecs.push_back(mk("=",                  1, "",                 1));
        vecs.push_back(mk("  =",                1, "",                 1));
        vecs.push_back(mk("7*2=",               0, "7*2=",             1));
        vecs.push_back(mk("f-a =",              1, "f-a=",             0));
        vecs.push_back(mk("1A2=",               1, "",                 1));
        vecs.push_back(mk("c",                  1, "",                 0));
        vecs.push_back(mk("*(=",                1, "c*(=",             0));

        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; aec_valid = 1'b0;
        #1 rst = 1'b1;
        #2;
        check_int("rst.in_ready", in_ready, 0);
        check_int("rst.ascii_out", ascii_out, 0);
        check_int("rst.ready_out", ready_out, 0);
        check_int("rst.err", err, 0);
        check_int("rst.busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 check_int("post_rst.in_ready", in_ready, 1);

        // Exact burst timing for "3+4=" with in_valid held high
        e0 = mon_err;
        exp_s = "3+4=";
        for (int i = 0; i < exp_s.len(); i++) push_byte(exp_s[i]);
        check_int("t34.in_ready_after_eq", in_ready, 0);
        check_int("t34.ready_before_burst", ready_out, 0);
        for (int i = 0; i < exp_s.len(); i++) begin
            @(posedge clk); #1;
            check_int($sformatf("t34.ready[%0d]", i), ready_out, 1);
            check_int($sformatf("t34.ascii[%0d]", i), ascii_out, exp_s[i]);
            check_int($sformatf("t34.busy[%0d]", i), busy, 1);
        end
        @(posedge clk); #1;
        check_int("t34.ready_end", ready_out, 0);
        check_int("t34.ascii_end", ascii_out, 0);
        repeat (4) @(posedge clk);
        #1 aec_valid = 1'b1;
        check_int("t34.in_ready_with_aec", in_ready, 0);
        @(posedge clk); #1;
        aec_valid = 1'b0;
        check_int("t34.in_ready_after_aec", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 check_int("t34.busy_after", busy, 0);
        check_int("t34.no_err", mon_err - e0, 0);

        // Lone '=' is rejected and stays in COLLECT
        push_byte("=");
        check_int("lone.err", err, 1);
        check_int("lone.in_ready", in_ready, 1);
        @(posedge clk); #1;
        check_int("lone.err_one_cycle", err, 0);

        // Timeout: 4 chars sent, then 64 WAIT cycles, then the err pulse
        exp_s = "7*2=";
        for (int i = 0; i < exp_s.len(); i++) push_byte(exp_s[i]);
        for (int k = 1; k <= 4 + TIMEOUT + 1; k++) begin
            @(posedge clk); #1;
            if (k == 4 + TIMEOUT - 1) begin
                check_int("to.err_early", err, 0);
                check_int("to.in_ready_early", in_ready, 0);
            end
            if (k == 4 + TIMEOUT) begin
                check_int("to.err", err, 1);
                check_int("to.in_ready", in_ready, 1);
            end
            if (k == 4 + TIMEOUT + 1) check_int("to.err_one_cycle", err, 0);
        end

        // Reset two chars into a 6-char burst
        e0 = mon_err;
        exp_s = "12345=";
        for (int i = 0; i < exp_s.len(); i++) push_byte(exp_s[i]);
        repeat (2) @(posedge clk);
        #1 check_int("mid.ascii_before_rst", ascii_out, 8'h32);
        rst = 1'b1;
        #1;
        check_int("mid.ascii", ascii_out, 0);
        check_int("mid.ready", ready_out, 0);
        check_int("mid.in_ready", in_ready, 0);
        check_int("mid.busy", busy, 0);
        @(posedge clk); #1;
        check_int("mid.in_ready_held", in_ready, 0);
        check_int("mid.ready_held", ready_out, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_int("mid.no_err", mon_err - e0, 0);
        check_expr("mid.after", "9=", 1'b1, "9=", 0, 0);

        // Table-driven expressions, alternating held and gappy input
        foreach (vecs[i])
            check_expr($sformatf("vec%0d", i), vecs[i].stim, vecs[i].respond,
                       vecs[i].exp, vecs[i].exp_err, (i % 2) * 2);

        // Random expressions against the model
        legal_pool = "0123456789abcdef()*+-";
        bad_pool = "Ag/>#Z";
        for (int n = 0; n < 40; n++) begin
            s = "";
            len = $urandom_range(0, 17);
            for (int k = 0; k < len; k++) begin
                r = $urandom_range(0, 99);
                if (r < 12) begin
                    c = " ";
                end else if (r < 15) begin
                    idx = $urandom_range(0, bad_pool.len() - 1);
                    c = bad_pool[idx];
                end else begin
                    idx = $urandom_range(0, legal_pool.len() - 1);
                    c = legal_pool[idx];
                end
                s = $sformatf("%s%c", s, c);
            end
            s = {s, "="};
            resp = ($urandom_range(0, 3) != 0);
            model(s, resp, exp_s, exp_e);
            check_expr($sformatf("rnd%0d", n), s, resp, exp_s, exp_e, $urandom_range(0, 2));
        end

        act = "";
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/aec_feeder.md
Name: aec_feeder

Overview:
- Upstream stage of the arithmetic expression calculator.
- Accepts a raw ASCII byte stream from a byte source using a valid/ready handshake.
- Strips spaces, validates characters and length, and buffers one complete expression up to '='.
- Replays the buffered expression to the calculator as a contiguous burst, one char per cycle, then holds off new input until the calculator reports its result valid (or a timeout expires).

Parameters:
DEPTH, 16, expression buffer entries including the terminating '='
TIMEOUT, 64, max cycles in WAIT for the calculator's result valid

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  source byte valid
in_data  input  8  source ASCII byte
in_ready  output  1  feeder can accept a byte this cycle
ascii_out  output  8  char to calculator (ascii_in)
ready_out  output  1  ascii_out carries a valid char
aec_valid  input  1  calculator result-valid pulse
err  output  1  one-cycle pulse: expression dropped or timed out
busy  output  1  high in SEND and WAIT

Behaviour:
- Reset values: in_ready=0, ascii_out=8'h00, ready_out=0, err=0, busy=0; state=COLLECT; wr_cnt=0; rd_idx=0; to_cnt=0.
- Buffer contents are not reset.
- Legal chars: '0'-'9' (0x30-0x39), 'a'-'f' (0x61-0x66), '(' ')' '*' '+' '-' '='. Space 0x20 is discarded silently. Any other byte is illegal.
- A byte is accepted on an edge where in_valid && in_ready.
- in_ready is combinational: 1 in COLLECT and DROP, 0 otherwise.
- States:
  - COLLECT:
    - accepted space: no effect.
    - accepted legal non-'=': if wr_cnt==DEPTH-1, go to DROP (overflow, no slot left for '='); else buf[wr_cnt]<=byte, wr_cnt++.
    - accepted illegal: go to DROP.
    - accepted '=' with wr_cnt==0: err pulse, stay in COLLECT.
    - accepted '=' with wr_cnt>0: buf[wr_cnt]<='=', wr_cnt++, rd_idx<=0, go to SEND.
  - DROP: discard all bytes. On accepted '=': err<=1 for one cycle, wr_cnt<=0, go to COLLECT.
  - SEND: each edge, ascii_out<=buf[rd_idx], ready_out<=1, rd_idx++. The edge that loads buf[wr_cnt-1] also moves to WAIT and clears to_cnt.
  - WAIT: first edge sets ascii_out<=8'h00, ready_out<=0. to_cnt increments each cycle.
    - aec_valid=1: wr_cnt<=0, go to COLLECT.
    - to_cnt reaches TIMEOUT-1 without aec_valid: err pulse, wr_cnt<=0, go to COLLECT.
- Latency: '=' accepted on edge E0; buf[i] is driven during the cycle after edge E(i+1). N chars are emitted on N consecutive cycles with no gaps. ready_out deasserts on the edge after the last char.
- Outside SEND, ascii_out=8'h00 and ready_out=0.
- aec_valid is ignored in COLLECT, DROP and SEND.
- err is registered: high exactly one cycle per dropped expression or timeout.
- Counter widths: wr_cnt and rd_idx are $clog2(DEPTH+1) bits; to_cnt is $clog2(TIMEOUT+1) bits. No wrap: counts are bounded by the state logic.
- busy = (state==SEND || state==WAIT), registered.
- Reset mid-operation (any state): immediate return to reset values. A partially sent burst is abandoned, with no err pulse.
- Back-to-back expressions: the byte arriving in the same cycle aec_valid is seen in WAIT is not accepted (in_ready=0). It is accepted next cycle in COLLECT.

Test Plan:
- "3+4=" with in_valid held high → in_ready drops after '=' is accepted; ascii_out=0x33, 0x2B, 0x34, 0x3D on 4 consecutive cycles with ready_out=1; then 0x00 and ready_out=0. Pulse aec_valid 5 cycles later → in_ready=1 next cycle, err never asserted.
- "( 1 + 2 ) * 3 =" → exactly 8 chars emitted, "(1+2)*3=", no 0x20; busy high from the first emitted char until aec_valid.
- "1+g2=" then "5-2=" → err pulse one cycle after the first '=', nothing emitted for the first expression; the second expression is emitted as 0x35, 0x2D, 0x32, 0x3D.
- 15 legal digits, a 16th digit, then "=" → DROP on the 16th digit, err pulse after '=', ready_out never asserted. A 15-digit + '=' expression (16 entries) is emitted fully.
- Lone "=" → err pulse, state stays COLLECT. "7*2=" with no aec_valid → err pulse after 64 WAIT cycles, then in_ready=1.
- Assert rst two chars into a 6-char SEND burst → ascii_out=0x00, ready_out=0, in_ready=0 while rst is high. After release, "9=" is emitted normally.
